// File: rtl/pe_ws.sv
// Weight-stationary systolic PE: double-buffered weight fed by a shift chain,
// one-cycle activation forwarding and a registered, optionally saturating MAC.
module pe_ws #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    input  logic              w_commit,
    output logic [DATA_W-1:0] w_out,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out,
    input  logic              ovf_clr,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int EXT_W  = ACC_W + 1;

    logic [DATA_W-1:0] w_shadow_reg;
    logic [DATA_W-1:0] w_active_reg;
    logic [DATA_W-1:0] a_reg;
    logic              a_v_reg;
    logic [ACC_W-1:0]  psum_reg;
    logic              psum_v_reg;
    logic              ovf_reg;

    logic [PROD_W-1:0] a_wide;
    logic [PROD_W-1:0] w_wide;
    logic [PROD_W-1:0] prod;
    logic [EXT_W-1:0]  prod_ext;
    logic [EXT_W-1:0]  psum_ext;
    logic [EXT_W-1:0]  sum;
    logic              ovf_now;
    logic [ACC_W-1:0]  sat_val;
    logic [ACC_W-1:0]  psum_next;

    // Extending both operands to the full product width before multiplying
    // gives the exact signed or unsigned product in the low PROD_W bits.
    assign a_wide   = {{DATA_W{SIGNED & a_in[DATA_W-1]}}, a_in};
    assign w_wide   = {{DATA_W{SIGNED & w_active_reg[DATA_W-1]}}, w_active_reg};
    assign prod     = a_wide * w_wide;
    assign prod_ext = {{(EXT_W - PROD_W){SIGNED & prod[PROD_W-1]}}, prod};
    assign psum_ext = {SIGNED & psum_in[ACC_W-1], psum_in};
    assign sum      = psum_ext + prod_ext;

    // Signed: the extra sum bit disagreeing with the ACC_W sign bit means the
    // result left the representable range; unsigned: any carry out.
    assign ovf_now = SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];

    always_comb begin
        sat_val = '1;
        if (SIGNED) begin
            sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end
        psum_next = (SAT && ovf_now) ? sat_val : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_shadow_reg <= '0;
            w_active_reg <= '0;
            a_reg        <= '0;
            a_v_reg      <= 1'b0;
            psum_reg     <= '0;
            psum_v_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            if (w_load) begin
                w_shadow_reg <= w_in;
            end
            // Reads the pre-load shadow, so a same-cycle load lands one weight later.
            if (w_commit) begin
                w_active_reg <= w_shadow_reg;
            end
            a_reg      <= a_in;
            a_v_reg    <= a_valid_in;
            psum_v_reg <= a_valid_in;
            if (a_valid_in) begin
                psum_reg <= psum_next;
            end
            if (a_valid_in && ovf_now) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign w_out          = w_shadow_reg;
    assign a_out          = a_reg;
    assign a_valid_out    = a_v_reg;
    assign psum_out       = psum_reg;
    assign psum_valid_out = psum_v_reg;
    assign ovf            = ovf_reg;

endmodule

// File: tb/tb_pe_ws.sv
// Bench for pe_ws: seven instances (several ACC_W/SIGNED/SAT variants plus a
// two-deep weight chain) against an arithmetic reference model.
module tb_pe_ws;

    localparam int N = 7;

    function automatic int acc_of(input int i);
        return (i >= 1 && i <= 4) ? 16 : 24;
    endfunction
    function automatic bit sgn_of(input int i);
        return !(i == 3 || i == 4);
    endfunction
    function automatic bit sat_of(input int i);
        return !(i == 2 || i == 4);
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  w_in;
    logic        w_load;
    logic        w_commit;
    logic [7:0]  a_in;
    logic        a_valid;
    logic [23:0] psum_in;
    logic        ovf_clr;

    logic [7:0]  w_out_v  [N];
    logic [7:0]  a_out_v  [N];
    logic        av_out_v [N];
    logic [23:0] psum_out_v [N];
    logic        pv_out_v [N];
    logic        ovf_v    [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults. 1..4: ACC_W=16 with every SIGNED/SAT mix.
    // 5 feeds its shadow weight to 6 (a column of two).
    for (genvar gi = 0; gi < N; gi++) begin : g_pe
        localparam int AW = acc_of(gi);
        logic [7:0]    wi;
        logic [AW-1:0] po;
        if (gi == 6) begin : g_chain
            assign wi = w_out_v[5];
        end else begin : g_edge
            assign wi = w_in;
        end
        pe_ws #(.DATA_W(8), .ACC_W(AW), .SIGNED(sgn_of(gi)), .SAT(sat_of(gi))) u_pe (
            .clk            (clk),
            .rst_n          (rst_n),
            .w_in           (wi),
            .w_load         (w_load),
            .w_commit       (w_commit),
            .w_out          (w_out_v[gi]),
            .a_in           (a_in),
            .a_valid_in     (a_valid),
            .a_out          (a_out_v[gi]),
            .a_valid_out    (av_out_v[gi]),
            .psum_in        (psum_in[AW-1:0]),
            .psum_out       (po),
            .psum_valid_out (pv_out_v[gi]),
            .ovf_clr        (ovf_clr),
            .ovf            (ovf_v[gi])
        );
        assign psum_out_v[gi] = 24'(po);
    end

    // Reference state: what each PE should hold, in plain bench terms.
    logic [7:0]  m_sh  [N];
    logic [7:0]  m_act [N];
    logic [23:0] m_ps  [N];
    bit          m_pv  [N];
    bit          m_ov  [N];
    logic [7:0]  m_a;
    bit          m_av;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact integer arithmetic on the operands' numeric values, then clamp or wrap.
    function automatic void ref_mac(input int i, input logic [7:0] a, input logic [7:0] w,
                                    input logic [23:0] pin,
                                    output logic [23:0] res, output bit ov);
        int     aw   = acc_of(i);
        bit     sg   = sgn_of(i);
        longint mask = (longint'(1) << aw) - 1;
        longint av   = sg ? longint'($signed(a)) : longint'(a);
        longint wv   = sg ? longint'($signed(w)) : longint'(w);
        longint pv   = longint'(pin) & mask;
        longint hi   = sg ? (longint'(1) << (aw - 1)) - 1 : mask;
        longint lo   = sg ? -(longint'(1) << (aw - 1)) : 0;
        longint sum;
        if (sg && pv[aw-1]) pv = pv - (longint'(1) << aw);
        sum = pv + av * wv;
        ov  = (sum > hi) || (sum < lo);
        if (ov && sat_of(i)) sum = (sum > hi) ? hi : lo;
        res = 24'(sum & mask);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh[i] = '0; m_act[i] = '0; m_ps[i] = '0; m_pv[i] = 0; m_ov[i] = 0;
        end
        m_a  = '0;
        m_av = 0;
    endtask

    task automatic model_clock();
        logic [7:0]  sh_old [N];
        logic [23:0] r;
        bit          o;
        for (int i = 0; i < N; i++) sh_old[i] = m_sh[i];
        for (int i = 0; i < N; i++) begin
            if (a_valid) begin
                ref_mac(i, a_in, m_act[i], psum_in, r, o);
                m_ps[i] = r;
            end else begin
                o = 0;
            end
            if (o) m_ov[i] = 1;
            else if (ovf_clr) m_ov[i] = 0;
            m_pv[i] = a_valid;
            if (w_commit) m_act[i] = sh_old[i];
            if (w_load) m_sh[i] = (i == 6) ? sh_old[5] : w_in;
        end
        m_a  = a_in;
        m_av = a_valid;
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("psum_out[%0d]", i), 32'(psum_out_v[i]), 32'(m_ps[i]));
            check($sformatf("psum_valid_out[%0d]", i), 32'(pv_out_v[i]), 32'(m_pv[i]));
            check($sformatf("ovf[%0d]", i), 32'(ovf_v[i]), 32'(m_ov[i]));
            check($sformatf("w_out[%0d]", i), 32'(w_out_v[i]), 32'(m_sh[i]));
            check($sformatf("a_out[%0d]", i), 32'(a_out_v[i]), 32'(m_a));
            check($sformatf("a_valid_out[%0d]", i), 32'(av_out_v[i]), 32'(m_av));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic set_idle();
        w_in = '0; w_load = 0; w_commit = 0; a_in = '0; a_valid = 0; psum_in = '0; ovf_clr = 0;
    endtask

    task automatic load_commit(input logic [7:0] w);
        set_idle(); w_in = w; w_load = 1; step();
        set_idle(); w_commit = 1; step();
        set_idle();
    endtask

    task automatic mac(input logic [7:0] a, input logic [23:0] p);
        set_idle(); a_in = a; psum_in = p; a_valid = 1; step();
        set_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, biased so that overflow and clears both occur often.
        for (int c = 0; c < 200; c++) begin
            w_in     = 8'($urandom);
            w_load   = ($urandom_range(0, 3) == 0);
            w_commit = ($urandom_range(0, 5) == 0);
            a_in     = 8'($urandom);
            a_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       psum_in = 24'h7FFF00 | 24'($urandom_range(0, 255));
                1:       psum_in = 24'($urandom_range(32000, 33000));
                2:       psum_in = 24'hFF8000 | 24'($urandom_range(0, 255));
                default: psum_in = 24'($urandom);
            endcase
            ovf_clr  = ($urandom_range(0, 7) == 0);
            step();
        end

        // Reset asserted mid-cycle while traffic is live: outputs clear at once.
        w_in = 8'hA5; w_load = 1; a_in = 8'h3C; a_valid = 1; psum_in = 24'h123456;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        mac(8'h55, 24'd7);
        check("reset_mac_psum", 32'(psum_out_v[0]), 32'd7);
        $display("[TB] mac after reset: psum_out=%0d", psum_out_v[0]);

        load_commit(8'd5);
        mac(8'hFD, 24'd100);
        check("signed_mac", 32'(psum_out_v[0]), 32'd85);
        check("signed_valid", 32'(pv_out_v[0]), 32'd1);
        check("signed_a_out", 32'(a_out_v[0]), 32'hFD);
        $display("[TB] signed mac: psum_out=%0d", $signed(psum_out_v[0]));
        step();
        check("signed_hold", 32'(psum_out_v[0]), 32'd85);
        check("signed_hold_valid", 32'(pv_out_v[0]), 32'd0);

        load_commit(8'd127);
        mac(8'd127, 24'd32760);
        check("sat_signed", 32'(psum_out_v[1]), 32'd32767);
        check("sat_signed_ovf", 32'(ovf_v[1]), 32'd1);
        check("wrap_signed_ovf", 32'(ovf_v[2]), 32'd1);
        $display("[TB] saturation: sat=%0d wrap=%0d", $signed(psum_out_v[1][15:0]), $signed(psum_out_v[2][15:0]));
        ovf_clr = 1; step(); set_idle();
        check("ovf_clear", 32'(ovf_v[1]), 32'd0);

        load_commit(8'd255);
        mac(8'd255, 24'd1000);
        check("unsigned_sat", 32'(psum_out_v[3]), 32'd65535);
        check("unsigned_wrap", 32'(psum_out_v[4]), 32'd489);
        check("unsigned_wrap_ovf", 32'(ovf_v[4]), 32'd1);
        $display("[TB] unsigned: sat=%0d wrap=%0d", psum_out_v[3], psum_out_v[4]);

        // Double buffer: shadow changes must not disturb the running stream.
        load_commit(8'd2);
        w_in = 8'd9; w_load = 1; a_in = 8'd1; a_valid = 1; step();
        check("dbuf_load", 32'(psum_out_v[0]), 32'd2);
        w_load = 0; step();
        check("dbuf_run", 32'(psum_out_v[0]), 32'd2);
        w_in = 8'd4; w_load = 1; w_commit = 1; step();
        check("dbuf_commit_cycle", 32'(psum_out_v[0]), 32'd2);
        w_load = 0; w_commit = 0; step();
        check("dbuf_after_commit", 32'(psum_out_v[0]), 32'd9);
        check("dbuf_shadow", 32'(w_out_v[0]), 32'd4);
        $display("[TB] double buffer: psum_out=%0d shadow=%0d", psum_out_v[0], w_out_v[0]);
        set_idle();

        w_in = 8'd3; w_load = 1; step();
        w_in = 8'd6; step();
        check("chain_top", 32'(w_out_v[5]), 32'd6);
        check("chain_bottom", 32'(w_out_v[6]), 32'd3);
        set_idle(); w_commit = 1; step();
        mac(8'd1, 24'd0);
        check("chain_top_mac", 32'(psum_out_v[5]), 32'd6);
        check("chain_bottom_mac", 32'(psum_out_v[6]), 32'd3);
        $display("[TB] chain: top=%0d bottom=%0d", psum_out_v[5], psum_out_v[6]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
